find_max_scanner: RTL and testbench
===================================

// Module: find_max_scanner
// PURPOSE
//  Sequencer-driven max search over LEN words of a synchronous block RAM.
//  Issues the addresses itself, compares on the fly and returns the max value and its index.
//  Parametrised width/depth, signed/unsigned compare and optional min tracking.
//  Sits between the control FSM (start/done handshake) and the BRAM read port (addr/en/dout).
// PARAMETERS
//  DATA_W  16  word width of mem_dout and result values
//  ADDR_W  8   BRAM address width; max scan length 2**ADDR_W
//  SIGNED  0   0: unsigned compare, 1: two's-complement compare
// PORTS
//  clk         in   1         rising-edge clock
//  reset       in   1         asynchronous, active-low reset
//  start       in   1         scan request; sampled only in IDLE
//  len         in   ADDR_W+1  number of words to scan from addr 0; sampled with start
//  mem_en      out  1         BRAM read enable
//  mem_addr    out  ADDR_W    BRAM read address
//  mem_dout    in   DATA_W    BRAM data; valid 1 cycle after mem_en/mem_addr
//  busy        out  1         high from start acceptance until done
//  done        out  1         1-cycle pulse; results valid from this cycle
//  res_valid   out  1         1 = results meaningful (len was non-zero)
//  max_val     out  DATA_W    largest word found
//  max_idx     out  ADDR_W    address of first occurrence of max_val
//  min_val     out  DATA_W    smallest word (FINDMAX_MIN_EN only)
//  min_idx     out  ADDR_W    address of first occurrence of min_val (FINDMAX_MIN_EN only)
// BEHAVIOUR
//  - Reset (reset=0): state IDLE; all outputs 0. Effective immediately, including mid-scan;
//    any scan in progress is abandoned with no done pulse.
//  - FSM states:
//    - IDLE: start=1 & len>0 -> READ. Latches len, sets addr=0 and busy=1.
//            start=1 & len=0 -> DONE with res_valid=0.
//    - READ: mem_en=1; mem_addr counts 0..len-1, one per cycle. After len-1 is issued -> DRAIN.
//    - DRAIN: compares the final word -> DONE.
//    - DONE: done=1 and busy=0 for exactly 1 cycle -> IDLE.
//  - Compare pipeline: a 1-bit valid shadow of mem_en, delayed 1 cycle, qualifies mem_dout;
//    an index shadow register tracks the address of each returned word.
//  - First valid word loads max (and min) unconditionally; there is no compare against stale
//    or zero state.
//  - Updates use strict > (and < for min); ties keep the lowest index.
//  - Latency: if start is accepted at edge T, done is high in the cycle after edge T+len+2.
//    len=0 gives done 1 cycle after acceptance.
//  - max_val, max_idx, min_val, min_idx and res_valid are cleared when a start is accepted.
//    They hold their values after done until the next accepted start.
//  - start while busy is ignored; no queueing.
//  - len > 2**ADDR_W is clamped to 2**ADDR_W.
//  - mem_addr never wraps: the counter stops at len-1.
// CONFIGURATION
//  FINDMAX_MIN_EN defined: min_val/min_idx ports and the min compare path exist.
//  FINDMAX_MIN_EN undefined: those ports and the min logic are absent; max behaviour is identical.
// STRUCTURE
//  Package findmax_pkg holds:
//    - the state enum (IDLE, READ, DRAIN, DONE);
//    - a cmp_gt function honouring SIGNED.
//  One sub-module, findmax_cmp_stage: valid-qualified running-extreme register with
//  value and index. It is instantiated once for max and once for min (min under the macro).
//  The top holds the FSM and the address counter.
// TESTING
//  1. Unsigned, len=6, RAM = 1,5,4,6,5,0x0878 -> done at T+8; max_val=0x0878, max_idx=5;
//     min_val=1, min_idx=0; res_valid=1.
//  2. SIGNED=1, RAM = 0xFFFF,0x0001,0x8000 -> max_val=0x0001 idx 1; min_val=0x8000 idx 2.
//     With SIGNED=0 -> max_val=0xFFFF idx 0.
//  3. Ties, RAM = 7,9,9,3 -> max_idx=1; min_idx=3.
//  4. len=0 -> done 1 cycle after start; res_valid=0; max_val=0; mem_en never asserted.
//  5. Reset asserted at READ addr 2 -> all outputs 0 asynchronously; no done pulse.
//     A new start=1, len=4 then completes normally.
//  6. start pulsed again mid-scan with len=2 -> ignored: the original len=6 scan completes
//     with the test-1 results and a single done pulse.

Source files
------------

// File: rtl/findmax_pkg.sv
// Shared types and helpers for the find_max_scanner block: FSM state encoding and
// a width-agnostic greater-than that handles both unsigned and two's-complement words.
package findmax_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Operands are zero-extended to this width by callers; DATA_W must not exceed it.
    localparam int CMP_W = 64;

    // Signed compare is done as an unsigned compare with the sign bit inverted.
    function automatic logic cmp_gt(
        input logic [CMP_W-1:0] a,
        input logic [CMP_W-1:0] b,
        input int unsigned      width,
        input bit               is_signed
    );
        logic [CMP_W-1:0] flip;
        flip = '0;
        if (is_signed) begin
            flip = {{(CMP_W-1){1'b0}}, 1'b1} << (width - 1);
        end
        return (a ^ flip) > (b ^ flip);
    endfunction

endpackage

// File: rtl/findmax_cmp_stage.sv
// Running-extreme register: registers each valid BRAM word with its index, then keeps
// the largest (FIND_MAX=1) or smallest (FIND_MAX=0) value seen since the last clear.
module findmax_cmp_stage
    import findmax_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int SIGNED   = 0,
    parameter int FIND_MAX = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_idx,
    output logic [DATA_W-1:0] best_val,
    output logic [ADDR_W-1:0] best_idx
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              have_q, have_d;
    logic [DATA_W-1:0] best_val_q, best_val_d;
    logic [ADDR_W-1:0] best_idx_q, best_idx_d;
    logic              take;

    always_comb begin
        valid_d    = in_valid & ~clear;
        data_d     = in_valid ? in_data : data_q;
        idx_d      = in_valid ? in_idx : idx_q;
        take       = 1'b0;
        have_d     = have_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;

        // First word of a scan loads unconditionally; strict compare keeps the lowest index on ties.
        if (valid_q) begin
            if (!have_q) begin
                take = 1'b1;
            end else if (FIND_MAX != 0) begin
                take = cmp_gt(CMP_W'(data_q), CMP_W'(best_val_q), unsigned'(DATA_W), SIGNED != 0);
            end else begin
                take = cmp_gt(CMP_W'(best_val_q), CMP_W'(data_q), unsigned'(DATA_W), SIGNED != 0);
            end
        end

        if (clear) begin
            have_d     = 1'b0;
            best_val_d = '0;
            best_idx_d = '0;
        end else if (take) begin
            have_d     = 1'b1;
            best_val_d = data_q;
            best_idx_d = idx_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            idx_q      <= '0;
            have_q     <= 1'b0;
            best_val_q <= '0;
            best_idx_q <= '0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            have_q     <= have_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign best_val = best_val_q;
    assign best_idx = best_idx_q;

endmodule

// File: rtl/find_max_scanner.sv
// Sequencer that reads len words of a synchronous BRAM from address 0 and reports the
// max (and, with FINDMAX_MIN_EN defined, the min) value with its first index.
module find_max_scanner
    import findmax_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done,
    output logic              res_valid,
    output logic [DATA_W-1:0] max_val,
    output logic [ADDR_W-1:0] max_idx
`ifdef FINDMAX_MIN_EN
    ,
    output logic [DATA_W-1:0] min_val,
    output logic [ADDR_W-1:0] min_idx
`endif
);

    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic              res_valid_q, res_valid_d;
    logic              clear;
    logic [ADDR_W:0]   len_eff;
    logic [ADDR_W:0]   len_m1;

    always_comb begin
        len_eff = (len > LEN_MAX) ? LEN_MAX : len;
        len_m1  = len_eff - (ADDR_W+1)'(1);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_d      = last_q;
        res_valid_d = res_valid_q;
        clear       = 1'b0;
        mem_en      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    clear       = 1'b1;
                    res_valid_d = 1'b0;
                    addr_d      = '0;
                    if (len != '0) begin
                        last_d  = len_m1[ADDR_W-1:0];
                        state_d = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                mem_en = 1'b1;
                busy   = 1'b1;
                if (addr_q == last_q) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            // Wait until the last returned word has left the read shadow and been compared.
            DRAIN: begin
                busy = 1'b1;
                if (!rd_valid_q) begin
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_valid_d = mem_en;
        rd_idx_d   = addr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_q      <= '0;
            rd_valid_q  <= 1'b0;
            rd_idx_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            rd_valid_q  <= rd_valid_d;
            rd_idx_q    <= rd_idx_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign mem_addr  = addr_q;
    assign res_valid = res_valid_q;

    findmax_cmp_stage #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .SIGNED   (SIGNED),
        .FIND_MAX (1)
    ) u_max (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (rd_valid_q),
        .in_data  (mem_dout),
        .in_idx   (rd_idx_q),
        .best_val (max_val),
        .best_idx (max_idx)
    );

`ifdef FINDMAX_MIN_EN
    findmax_cmp_stage #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .SIGNED   (SIGNED),
        .FIND_MAX (0)
    ) u_min (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (rd_valid_q),
        .in_data  (mem_dout),
        .in_idx   (rd_idx_q),
        .best_val (min_val),
        .best_idx (min_idx)
    );
`endif

endmodule

// File: tb/tb_find_max_scanner.sv
// Directed bench for find_max_scanner: an unsigned and a signed instance share one RAM image
// and one start/len stimulus; min results are checked when FINDMAX_MIN_EN is defined.
module tb_find_max_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  len;

    logic        mem_en_u, mem_en_s;
    logic [7:0]  mem_addr_u, mem_addr_s;
    logic [15:0] mem_dout_u, mem_dout_s;
    logic        busy_u, busy_s, done_u, done_s, res_valid_u, res_valid_s;
    logic [15:0] max_val_u, max_val_s;
    logic [7:0]  max_idx_u, max_idx_s;
`ifdef FINDMAX_MIN_EN
    logic [15:0] min_val_u, min_val_s;
    logic [7:0]  min_idx_u, min_idx_s;
`endif

    logic [15:0] ram [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_en_u) mem_dout_u <= ram[mem_addr_u];
        if (mem_en_s) mem_dout_s <= ram[mem_addr_s];
    end

    find_max_scanner #(.DATA_W(16), .ADDR_W(8), .SIGNED(0)) dut_u (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .mem_en(mem_en_u), .mem_addr(mem_addr_u), .mem_dout(mem_dout_u),
        .busy(busy_u), .done(done_u), .res_valid(res_valid_u),
        .max_val(max_val_u), .max_idx(max_idx_u)
`ifdef FINDMAX_MIN_EN
        , .min_val(min_val_u), .min_idx(min_idx_u)
`endif
    );

    find_max_scanner #(.DATA_W(16), .ADDR_W(8), .SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .mem_en(mem_en_s), .mem_addr(mem_addr_s), .mem_dout(mem_dout_s),
        .busy(busy_s), .done(done_s), .res_valid(res_valid_s),
        .max_val(max_val_s), .max_idx(max_idx_s)
`ifdef FINDMAX_MIN_EN
        , .min_val(min_val_s), .min_idx(min_idx_s)
`endif
    );

    typedef struct packed {
        logic [8:0]       len;
        logic [5:0][15:0] words;
        logic [15:0]      max_u;
        logic [7:0]       max_idx_u;
        logic [15:0]      max_s;
        logic [7:0]       max_idx_s;
        logic [15:0]      min_u;
        logic [7:0]       min_idx_u;
        logic [15:0]      min_s;
        logic [7:0]       min_idx_s;
        logic             res_valid;
        logic [9:0]       lat;
    } vec_t;

    vec_t vecs [6];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Issues one start and watches both instances for a bounded number of cycles.
    // Latency k means done was seen just after edge T+k, where T is the accepting edge.
    task automatic apply_stimulus(input logic [8:0] l, input int pulse_at,
                                  output int lat_u, output int lat_s,
                                  output int pulses_u, output int pulses_s, output int en_seen);
        lat_u = -1; lat_s = -1; pulses_u = 0; pulses_s = 0; en_seen = 0;
        @(negedge clk);
        start = 1'b1;
        len   = l;
        @(posedge clk);
        for (int k = 0; k <= int'(l) + 12; k++) begin
            #1;
            if (done_u) begin pulses_u++; if (lat_u < 0) lat_u = k; end
            if (done_s) begin pulses_s++; if (lat_s < 0) lat_s = k; end
            if (mem_en_u) en_seen++;
            @(negedge clk);
            if (k + 1 == pulse_at) begin
                start = 1'b1;
                len   = 9'd2;
            end else begin
                start = 1'b0;
                len   = l;
            end
            @(posedge clk);
        end
        start = 1'b0;
    endtask

    task automatic load_ram(input vec_t v);
        for (int i = 0; i < 256; i++) ram[i] = 16'hDEAD;
        for (int i = 0; i < 6; i++) begin
            if (i < int'(v.len)) ram[i] = v.words[i];
        end
    endtask

    task automatic check_results(input string tag, input vec_t v);
        check_output({tag, " res_valid_u"}, 32'(res_valid_u), 32'(v.res_valid));
        check_output({tag, " res_valid_s"}, 32'(res_valid_s), 32'(v.res_valid));
        check_output({tag, " max_val_u"}, 32'(max_val_u), 32'(v.max_u));
        check_output({tag, " max_idx_u"}, 32'(max_idx_u), 32'(v.max_idx_u));
        check_output({tag, " max_val_s"}, 32'(max_val_s), 32'(v.max_s));
        check_output({tag, " max_idx_s"}, 32'(max_idx_s), 32'(v.max_idx_s));
`ifdef FINDMAX_MIN_EN
        check_output({tag, " min_val_u"}, 32'(min_val_u), 32'(v.min_u));
        check_output({tag, " min_idx_u"}, 32'(min_idx_u), 32'(v.min_idx_u));
        check_output({tag, " min_val_s"}, 32'(min_val_s), 32'(v.min_s));
        check_output({tag, " min_idx_s"}, 32'(min_idx_s), 32'(v.min_idx_s));
`endif
    endtask

    task automatic check_idle_zero(input string tag);
        check_output({tag, " mem_en"}, 32'(mem_en_u), 32'd0);
        check_output({tag, " mem_addr"}, 32'(mem_addr_u), 32'd0);
        check_output({tag, " busy"}, 32'(busy_u), 32'd0);
        check_output({tag, " done"}, 32'(done_u), 32'd0);
        check_output({tag, " res_valid"}, 32'(res_valid_u), 32'd0);
        check_output({tag, " max_val"}, 32'(max_val_u), 32'd0);
        check_output({tag, " max_idx"}, 32'(max_idx_u), 32'd0);
    endtask

    initial begin
        int   lat_u, lat_s, pulses_u, pulses_s, en_seen;
        vec_t v;

        // Words are listed highest address first: words[0] is RAM address 0.
        vecs[0] = '{len: 9'd6, words: {16'h0878, 16'h0005, 16'h0006, 16'h0004, 16'h0005, 16'h0001},
                    max_u: 16'h0878, max_idx_u: 8'd5, max_s: 16'h0878, max_idx_s: 8'd5,
                    min_u: 16'h0001, min_idx_u: 8'd0, min_s: 16'h0001, min_idx_s: 8'd0,
                    res_valid: 1'b1, lat: 10'd8};
        vecs[1] = '{len: 9'd3, words: {16'h0, 16'h0, 16'h0, 16'h8000, 16'h0001, 16'hFFFF},
                    max_u: 16'hFFFF, max_idx_u: 8'd0, max_s: 16'h0001, max_idx_s: 8'd1,
                    min_u: 16'h0001, min_idx_u: 8'd1, min_s: 16'h8000, min_idx_s: 8'd2,
                    res_valid: 1'b1, lat: 10'd5};
        vecs[2] = '{len: 9'd4, words: {16'h0, 16'h0, 16'h0003, 16'h0009, 16'h0009, 16'h0007},
                    max_u: 16'h0009, max_idx_u: 8'd1, max_s: 16'h0009, max_idx_s: 8'd1,
                    min_u: 16'h0003, min_idx_u: 8'd3, min_s: 16'h0003, min_idx_s: 8'd3,
                    res_valid: 1'b1, lat: 10'd6};
        vecs[3] = '{len: 9'd1, words: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1234},
                    max_u: 16'h1234, max_idx_u: 8'd0, max_s: 16'h1234, max_idx_s: 8'd0,
                    min_u: 16'h1234, min_idx_u: 8'd0, min_s: 16'h1234, min_idx_s: 8'd0,
                    res_valid: 1'b1, lat: 10'd3};
        vecs[4] = '{len: 9'd3, words: {16'h0, 16'h0, 16'h0, 16'h0005, 16'h0005, 16'h0005},
                    max_u: 16'h0005, max_idx_u: 8'd0, max_s: 16'h0005, max_idx_s: 8'd0,
                    min_u: 16'h0005, min_idx_u: 8'd0, min_s: 16'h0005, min_idx_s: 8'd0,
                    res_valid: 1'b1, lat: 10'd5};
        vecs[5] = '{len: 9'd0, words: '0,
                    max_u: 16'h0, max_idx_u: 8'd0, max_s: 16'h0, max_idx_s: 8'd0,
                    min_u: 16'h0, min_idx_u: 8'd0, min_s: 16'h0, min_idx_s: 8'd0,
                    res_valid: 1'b0, lat: 10'd0};

        start = 1'b0;
        len   = '0;
        for (int i = 0; i < 256; i++) ram[i] = 16'hDEAD;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 check_idle_zero("por");
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        $display("[TB] table-driven scans");
        for (int n = 0; n < 6; n++) begin
            load_ram(vecs[n]);
            apply_stimulus(vecs[n].len, -1, lat_u, lat_s, pulses_u, pulses_s, en_seen);
            check_output($sformatf("v%0d lat_u", n), 32'(lat_u), 32'(vecs[n].lat));
            check_output($sformatf("v%0d lat_s", n), 32'(lat_s), 32'(vecs[n].lat));
            check_output($sformatf("v%0d pulses_u", n), 32'(pulses_u), 32'd1);
            check_output($sformatf("v%0d pulses_s", n), 32'(pulses_s), 32'd1);
            check_output($sformatf("v%0d en_cycles", n), 32'(en_seen), 32'(vecs[n].len));
            check_results($sformatf("v%0d", n), vecs[n]);
        end

        $display("[TB] len above depth is clamped");
        for (int i = 0; i < 256; i++) ram[i] = 16'(i);
        apply_stimulus(9'd300, -1, lat_u, lat_s, pulses_u, pulses_s, en_seen);
        check_output("clamp lat", 32'(lat_u), 32'd258);
        check_output("clamp pulses", 32'(pulses_u), 32'd1);
        check_output("clamp en_cycles", 32'(en_seen), 32'd256);
        check_output("clamp max_val_u", 32'(max_val_u), 32'h00FF);
        check_output("clamp max_idx_u", 32'(max_idx_u), 32'd255);
        check_output("clamp max_val_s", 32'(max_val_s), 32'h00FF);
        check_output("clamp mem_addr", 32'(mem_addr_u), 32'd255);

        $display("[TB] start during scan is ignored");
        load_ram(vecs[0]);
        apply_stimulus(9'd6, 3, lat_u, lat_s, pulses_u, pulses_s, en_seen);
        check_output("restart lat", 32'(lat_u), 32'd8);
        check_output("restart pulses", 32'(pulses_u), 32'd1);
        check_output("restart en_cycles", 32'(en_seen), 32'd6);
        check_results("restart", vecs[0]);

        $display("[TB] reset mid-scan");
        load_ram(vecs[0]);
        @(negedge clk);
        start = 1'b1;
        len   = 9'd6;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("midscan addr", 32'(mem_addr_u), 32'd2);
        check_output("midscan busy", 32'(busy_u), 32'd1);
        #1 reset = 1'b0;
        #1 check_idle_zero("async");
        pulses_u = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1 if (done_u) pulses_u++;
        end
        check_output("post-reset done pulses", 32'(pulses_u), 32'd0);
        check_output("post-reset busy", 32'(busy_u), 32'd0);

        v = vecs[2];
        load_ram(v);
        apply_stimulus(9'd4, -1, lat_u, lat_s, pulses_u, pulses_s, en_seen);
        check_output("after-reset lat", 32'(lat_u), 32'd6);
        check_output("after-reset pulses", 32'(pulses_u), 32'd1);
        check_results("after-reset", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
